// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - hazard inputs and pipeline-register controls of the stall sequencer
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [2:0]       ex_rd;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             memwb_bubble;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble,
               state, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble,
               state, stall_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - load-use / branch / memory-wait stall sequencer for the 5-stage pipeline
module pipeline_stall_ctrl #(
    parameter int LOAD_STALLS = 1,
    parameter int CNT_W       = 16
) (
    input logic                clk,
    input logic                rst,
    pipeline_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    state_t           eff_state;
    logic [2:0]       scnt_q, scnt_d;
    logic [CNT_W-1:0] count_q;
    logic             load_use;
    logic             hold;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble;

    assign load_use = bus.ex_mem_read && (bus.ex_rd != 3'd0) &&
                      ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    // While waiting, only mem_ready releases the freeze; the interrupted state resumes that cycle.
    assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
    assign hold      = (state_q == MEM_WAIT) ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        memwb_bubble = 1'b0;
        state_d      = state_q;
        ret_d        = ret_q;
        scnt_d       = scnt_q;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = RUN;
        end else if (hold) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
            state_d      = MEM_WAIT;
            ret_d        = eff_state;
        end else if (eff_state == LOAD_STALL) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (scnt_q == 3'd1) begin
                state_d = RUN;
            end else begin
                state_d = LOAD_STALL;
            end
            scnt_d = scnt_q - 3'd1;
        end else begin
            state_d = RUN;
            if (bus.branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                if (LOAD_STALLS > 1) begin
                    state_d = LOAD_STALL;
                    scnt_d  = 3'(LOAD_STALLS - 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            scnt_q  <= 3'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            scnt_q  <= scnt_d;
            if (!pc_en && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_en     = memwb_en;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.state        = state_q;
    assign bus.stall_count  = count_q;
endmodule
